// File: rtl/fan_tach_pkg.sv
// Shared constants, types and helpers for the multi-channel fan tachometer.
// Glitch filter option: define FAN_TACH_GLITCH_FILTER_EN.
package fan_tach_pkg;

  localparam int NUM_FANS_DEF  = 4;
  localparam int CNT_W_DEF     = 12;
  localparam int WIN_LOG2_DEF  = 15;
  localparam int FAIL_WINS_DEF = 3;

  // Consecutive equal samples needed before the filtered level may change.
  localparam int FILT_DEPTH = 3;
  localparam int BAD_W      = 4;

  typedef struct packed {
    logic tachLow;
    logic tachHigh;
    logic fanFail;
  } chanFlagsT;

  // Low bit index of channel 'chan' in a flat bus of 'width'-bit fields.
  function automatic int chanLsb(input int chan, input int width);
    return chan * width;
  endfunction

endpackage

// File: rtl/fan_tach_channel.sv
// One tach channel: synchroniser, optional glitch filter, edge counter,
// window-end threshold compare and fail debounce (FAN_TACH_GLITCH_FILTER_EN).
module fan_tach_channel
  import fan_tach_pkg::*;
#(
  parameter int CNT_W     = CNT_W_DEF,
  parameter int FAIL_WINS = FAIL_WINS_DEF
) (
  input  logic             CLKi,
  input  logic             ResetI,
  input  logic             FanIn,
  input  logic             ChanEn,
  input  logic             WinTc,
  input  logic [CNT_W-1:0] LowThr,
  input  logic [CNT_W-1:0] HighThr,
  output logic [CNT_W-1:0] FanFreq,
  output logic             TachLow,
  output logic             TachHigh,
  output logic             FanFail
);

  localparam int EW = CNT_W + 1;

  logic             syncQ1, syncQ2;
  logic             lvl, lvlPrev, edgeDet;
  logic [EW-1:0]    edgeCnt;
  logic [EW:0]      edgeSum;
  logic [EW-1:0]    halfSum;
  logic [CNT_W-1:0] newFreq;
  logic [BAD_W-1:0] badCnt, badNext;
  chanFlagsT        flagsQ, flagsNext;

  always_ff @(posedge CLKi) begin
    if (ResetI) begin
      syncQ1 <= 1'b0;
      syncQ2 <= 1'b0;
    end else begin
      syncQ1 <= FanIn;
      syncQ2 <= syncQ1;
    end
  end

`ifdef FAN_TACH_GLITCH_FILTER_EN
  logic [FILT_DEPTH-2:0] filtHist;
  logic [FILT_DEPTH-1:0] filtWin;
  logic                  filtLvl;

  assign filtWin = {filtHist, syncQ2};

  always_ff @(posedge CLKi) begin
    if (ResetI) begin
      filtHist <= '0;
      filtLvl  <= 1'b0;
    end else begin
      filtHist <= filtWin[FILT_DEPTH-2:0];
      if (&filtWin)       filtLvl <= 1'b1;
      else if (~|filtWin) filtLvl <= 1'b0;
    end
  end

  assign lvl = filtLvl;
`else
  assign lvl = syncQ2;
`endif

  always_ff @(posedge CLKi) begin
    if (ResetI) lvlPrev <= 1'b0;
    else        lvlPrev <= lvl;
  end

  assign edgeDet = lvl ^ lvlPrev;

  // NOTE: next-state logic uses blocking '=' with every output assigned on
  // every path, so no latch is inferred; registers below use '<=' only.
  always_comb begin
    edgeSum = {1'b0, edgeCnt} + (EW+1)'(edgeDet);
    halfSum = edgeSum[EW:1];
    newFreq = halfSum[CNT_W] ? {CNT_W{1'b1}} : halfSum[CNT_W-1:0];

    flagsNext          = '0;
    flagsNext.tachLow  = (newFreq <= LowThr);
    flagsNext.tachHigh = (newFreq > HighThr);

    if (flagsNext.tachLow || flagsNext.tachHigh)
      badNext = (badCnt >= BAD_W'(FAIL_WINS)) ? BAD_W'(FAIL_WINS) : badCnt + BAD_W'(1);
    else
      badNext = '0;
    flagsNext.fanFail = (badNext == BAD_W'(FAIL_WINS));
  end

  // A disabled channel is held in its reset state; the edge on the TC cycle
  // is folded into the closing window via edgeSum.
  always_ff @(posedge CLKi) begin
    if (ResetI || !ChanEn) begin
      edgeCnt <= '0;
      FanFreq <= '0;
      badCnt  <= '0;
      flagsQ  <= '0;
    end else if (WinTc) begin
      edgeCnt <= '0;
      FanFreq <= newFreq;
      badCnt  <= badNext;
      flagsQ  <= flagsNext;
    end else if (edgeDet && !(&edgeCnt)) begin
      edgeCnt <= edgeCnt + EW'(1);
    end
  end

  assign TachLow  = flagsQ.tachLow;
  assign TachHigh = flagsQ.tachHigh;
  assign FanFail  = flagsQ.fanFail;

endmodule

// File: rtl/fan_tach_monitor.sv
// Multi-channel fan tach monitor: shared measurement window plus one
// fan_tach_channel per fan. Optional filter: FAN_TACH_GLITCH_FILTER_EN.
module fan_tach_monitor
  import fan_tach_pkg::*;
#(
  parameter int NUM_FANS  = NUM_FANS_DEF,
  parameter int CNT_W     = CNT_W_DEF,
  parameter int WIN_LOG2  = WIN_LOG2_DEF,
  parameter int FAIL_WINS = FAIL_WINS_DEF
) (
  input  logic                      CLKi,
  input  logic                      ResetI,
  input  logic [NUM_FANS-1:0]       Fan_In,
  input  logic [NUM_FANS-1:0]       ChanEn,
  input  logic [NUM_FANS*CNT_W-1:0] LowThr,
  input  logic [NUM_FANS*CNT_W-1:0] HighThr,
  output logic [NUM_FANS*CNT_W-1:0] FanFreq,
  output logic [NUM_FANS-1:0]       TachLow,
  output logic [NUM_FANS-1:0]       TachHigh,
  output logic [NUM_FANS-1:0]       FanFail,
  output logic                      WinDone
);

  logic [WIN_LOG2-1:0] winCnt;
  logic                winTc;

  assign winTc = &winCnt;

  // Reset restarts the window from zero, so no partial window is reported.
  always_ff @(posedge CLKi) begin
    if (ResetI) begin
      winCnt  <= '0;
      WinDone <= 1'b0;
    end else begin
      winCnt  <= winCnt + WIN_LOG2'(1);
      WinDone <= winTc;
    end
  end

  for (genvar i = 0; i < NUM_FANS; i++) begin : gChan
    fan_tach_channel #(
      .CNT_W     (CNT_W),
      .FAIL_WINS (FAIL_WINS)
    ) uChan (
      .CLKi     (CLKi),
      .ResetI   (ResetI),
      .FanIn    (Fan_In[i]),
      .ChanEn   (ChanEn[i]),
      .WinTc    (winTc),
      .LowThr   (LowThr[chanLsb(i, CNT_W) +: CNT_W]),
      .HighThr  (HighThr[chanLsb(i, CNT_W) +: CNT_W]),
      .FanFreq  (FanFreq[chanLsb(i, CNT_W) +: CNT_W]),
      .TachLow  (TachLow[i]),
      .TachHigh (TachHigh[i]),
      .FanFail  (FanFail[i])
    );
  end

endmodule

// File: tb/tb_fan_tach_monitor.sv
// Directed bench for fan_tach_monitor: 64-cycle window, 2 channels, CNT_W=8,
// plus a CNT_W=4 instance for saturation.
module tb_fan_tach_monitor;

`ifdef FAN_TACH_GLITCH_FILTER_EN
  localparam int TC_OFF     = 58;
  localparam int PULSE2_EXP = 0;
`else
  localparam int TC_OFF     = 61;
  localparam int PULSE2_EXP = 4;
`endif

  logic        CLKi = 1'b0;
  logic        ResetI;
  logic [1:0]  Fan_In;
  logic [1:0]  ChanEn;
  logic [15:0] LowThr, HighThr, FanFreq;
  logic [1:0]  TachLow, TachHigh, FanFail;
  logic        WinDone;

  logic [7:0]  lowS, highS, freqS;
  logic [1:0]  lowFS, highFS, failS;
  logic        doneS;

  fan_tach_monitor #(.NUM_FANS(2), .CNT_W(8), .WIN_LOG2(6), .FAIL_WINS(3)) dut (
    .CLKi(CLKi), .ResetI(ResetI), .Fan_In(Fan_In), .ChanEn(ChanEn),
    .LowThr(LowThr), .HighThr(HighThr), .FanFreq(FanFreq),
    .TachLow(TachLow), .TachHigh(TachHigh), .FanFail(FanFail), .WinDone(WinDone)
  );

  fan_tach_monitor #(.NUM_FANS(2), .CNT_W(4), .WIN_LOG2(6), .FAIL_WINS(3)) dutSat (
    .CLKi(CLKi), .ResetI(ResetI), .Fan_In(Fan_In), .ChanEn(ChanEn),
    .LowThr(lowS), .HighThr(highS), .FanFreq(freqS),
    .TachLow(lowFS), .TachHigh(highFS), .FanFail(failS), .WinDone(doneS)
  );

  always #5 CLKi = ~CLKi;

  int total = 0;
  int bad   = 0;

  // Tach stimulus: period 0 follows 'manual', otherwise toggle every 'period' cycles.
  int         period[2] = '{0, 0};
  int         phase[2]  = '{0, 0};
  logic [1:0] genLvl    = 2'b00;
  logic [1:0] manual    = 2'b00;

  initial begin
    Fan_In = 2'b00;
    forever begin
      @(posedge CLKi);
      #2;
      for (int ch = 0; ch < 2; ch++) begin
        if (period[ch] == 0) begin
          Fan_In[ch] = manual[ch];
        end else begin
          phase[ch]++;
          if (phase[ch] >= period[ch]) begin
            phase[ch]   = 0;
            genLvl[ch]  = ~genLvl[ch];
          end
          Fan_In[ch] = genLvl[ch];
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      @(posedge CLKi);
      #1;
    end
  endtask

  task automatic waitWin(output int cycles);
    logic found;
    found  = 1'b0;
    cycles = 0;
    while (cycles < 200 && !found) begin
      @(posedge CLKi);
      #1;
      cycles++;
      found = WinDone;
    end
    if (!found) check("windone_timeout", 32'd0, 32'd1);
  endtask

  typedef struct {
    int         p0, p1;
    logic [7:0] lo0, hi0, lo1, hi1;
    logic [1:0] en;
    logic [7:0] f0, f1;
    logic [1:0] lo, hi, fail;
  } vecT;

  vecT  vecs[7];
  int   n;
  logic lvl0;
  logic [7:0] dbLow[6]  = '{8'd10, 8'd10, 8'd2, 8'd10, 8'd10, 8'd10};
  logic       dbFail[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  initial begin
    //            p0 p1 lo0 hi0 lo1 hi1 en     f0  f1 lo     hi     fail
    vecs[0] = '{4, 8,  2, 20,  2, 20, 2'b11,  8,  4, 2'b00, 2'b00, 2'b00};
    vecs[1] = '{2, 16, 2, 20,  2, 20, 2'b11, 16,  2, 2'b10, 2'b00, 2'b00};
    vecs[2] = '{2, 16, 2, 20,  2, 20, 2'b11, 16,  2, 2'b10, 2'b00, 2'b10};
    vecs[3] = '{1, 4,  2, 20,  2, 20, 2'b11, 32,  8, 2'b00, 2'b01, 2'b00};
    vecs[4] = '{1, 4,  2, 20, 10,  5, 2'b11, 32,  8, 2'b10, 2'b11, 2'b01};
    vecs[5] = '{1, 4,  2, 20, 10,  5, 2'b01, 32,  0, 2'b00, 2'b01, 2'b01};
    vecs[6] = '{4, 4,  2, 20,  2, 20, 2'b11,  8,  8, 2'b00, 2'b00, 2'b00};

    ResetI  = 1'b1;
    ChanEn  = 2'b11;
    LowThr  = {8'd2, 8'd2};
    HighThr = {8'd20, 8'd20};
    lowS    = {4'd2, 4'd2};
    highS   = {4'd10, 4'd10};
    ticks(3);
    check("reset_freq", FanFreq, 0);
    check("reset_low", TachLow, 0);
    check("reset_high", TachHigh, 0);
    check("reset_fail", FanFail, 0);
    check("reset_windone", WinDone, 0);

    ResetI = 1'b0;
    waitWin(n);
    check("first_windone_latency", n, 64);
    check("idle_freq", FanFreq, 0);
    check("idle_low", TachLow, 2'b11);
    check("idle_fail_w1", FanFail, 2'b00);
    waitWin(n);
    check("idle_fail_w2", FanFail, 2'b00);
    waitWin(n);
    check("idle_fail_w3", FanFail, 2'b11);

    // Each row: one settling window, then one fully steady window compared.
    for (int i = 0; i < 7; i++) begin
      period[0] = vecs[i].p0;
      period[1] = vecs[i].p1;
      LowThr    = {vecs[i].lo1, vecs[i].lo0};
      HighThr   = {vecs[i].hi1, vecs[i].hi0};
      ChanEn    = vecs[i].en;
      waitWin(n);
      waitWin(n);
      check($sformatf("row%0d_freq0", i), FanFreq[7:0], vecs[i].f0);
      check($sformatf("row%0d_freq1", i), FanFreq[15:8], vecs[i].f1);
      check($sformatf("row%0d_low", i), TachLow, vecs[i].lo);
      check($sformatf("row%0d_high", i), TachHigh, vecs[i].hi);
      check($sformatf("row%0d_fail", i), FanFail, vecs[i].fail);
    end

    // Debounce: out, out, in, out, out, out -> fail only after the sixth.
    for (int w = 0; w < 6; w++) begin
      LowThr[7:0] = dbLow[w];
      waitWin(n);
      check($sformatf("debounce_w%0d_low", w), TachLow[0], dbLow[w] == 8'd10);
      check($sformatf("debounce_w%0d_fail", w), FanFail[0], dbFail[w]);
    end

    ChanEn[0] = 1'b0;
    ticks(2);
    check("disable_freq0", FanFreq[7:0], 0);
    check("disable_low0", TachLow[0], 0);
    check("disable_fail0", FanFail[0], 0);
    ChanEn[0]   = 1'b1;
    LowThr[7:0] = 8'd2;

    // Toggle every cycle: 64 edges saturate the 4-bit instance.
    period[1] = 1;
    waitWin(n);
    waitWin(n);
    check("sat_freq1", freqS[7:4], 15);
    check("sat_high1", highFS[1], 1);
    check("wide_freq1", FanFreq[15:8], 32);
    period[1] = 4;

    // Edge reaching the counter on the TC cycle belongs to the closing window.
    manual[0] = Fan_In[0];
    period[0] = 0;
    waitWin(n);
    ticks(10);
    manual[0] = ~manual[0];
    ticks(TC_OFF - 10);
    manual[0] = ~manual[0];
    waitWin(n);
    check("tc_edge_closing", FanFreq[7:0], 1);
    ticks(20);
    manual[0] = ~manual[0];
    waitWin(n);
    check("tc_edge_next_start", FanFreq[7:0], 0);

    for (int p = 0; p < 4; p++) begin
      lvl0      = manual[0];
      manual[0] = ~lvl0;
      ticks(2);
      manual[0] = lvl0;
      ticks(4);
    end
    waitWin(n);
    check("pulse2_freq0", FanFreq[7:0], PULSE2_EXP);
    for (int p = 0; p < 4; p++) begin
      lvl0      = manual[0];
      manual[0] = ~lvl0;
      ticks(4);
      manual[0] = lvl0;
      ticks(4);
    end
    waitWin(n);
    check("pulse4_freq0", FanFreq[7:0], 4);

    // Reset in mid-window clears everything and restarts the window.
    period[0] = 4;
    waitWin(n);
    waitWin(n);
    check("pre_reset_freq0", FanFreq[7:0], 8);
    ticks(20);
    ResetI = 1'b1;
    ticks(1);
    check("midreset_freq", FanFreq, 0);
    check("midreset_low", TachLow, 0);
    check("midreset_high", TachHigh, 0);
    check("midreset_fail", FanFail, 0);
    check("midreset_windone", WinDone, 0);
    ResetI = 1'b0;
    waitWin(n);
    check("midreset_windone_latency", n, 64);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
